// File: rtl/led_pkg.sv
// Shared definitions for the LED framebuffer path: geometry, scheduler
// state encodings and the row-slice helper also used by led_matrix_driver.
package led_pkg;

    localparam int LED_ROWS = 8;
    localparam int LED_COLS = 8;
    localparam int FB_BITS  = LED_ROWS * LED_COLS;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PEND_SWAP = 2'd1,
        ST_INIT      = 2'd2
    } sched_state_t;

    // Base bit of row r in a flat framebuffer; use as fb[row_sel(r) +: LED_COLS].
    function automatic logic [5:0] row_sel(input logic [2:0] r);
        return {r, 3'b000};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-port round-robin arbiter: on a tie the port not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | last_gnt);
    assign gnt[1] = req[1] & (~req[0] | ~last_gnt);

endmodule

// File: rtl/led_frame_scheduler.sv
// Double-buffered 8x8 framebuffer owner: arbitrated row writes into the back
// buffer, tear-free swap at the scan wrap, then row-per-cycle back-buffer init.
//
// state        | meaning
// ST_IDLE      | accepting row writes from the two requesters
// ST_PEND_SWAP | frame committed, waiting for scan_idx == 7
// ST_INIT      | re-initialising back buffer, one row per cycle
module led_frame_scheduler
    import led_pkg::*;
#(
    parameter bit           SWAP_MODE  = 1'b0,
    parameter logic [63:0]  INIT_FRAME = 64'h0
) (
    input  logic        system_clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [2:0]  row0,
    input  logic [2:0]  row1,
    input  logic [7:0]  data0,
    input  logic [7:0]  data1,
    input  logic        commit0,
    input  logic        commit1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [63:0] framebuffer,
    output logic        busy,
    output logic        swap_pulse
);

    sched_state_t        state;
    logic [2:0]          scan_idx;
    logic [2:0]          init_row;
    logic                last_gnt;
    logic [FB_BITS-1:0]  front;
    logic [FB_BITS-1:0]  back;
    logic [1:0]          arb_gnt;
    logic                grant_en;

    rr_arb2 u_arb (
        .req      ({req1, req0}),
        .last_gnt (last_gnt),
        .gnt      (arb_gnt)
    );

    assign grant_en    = (state == ST_IDLE) && !rst;
    assign gnt0        = arb_gnt[0] & grant_en;
    assign gnt1        = arb_gnt[1] & grant_en;
    assign framebuffer = front;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge system_clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            scan_idx   <= 3'd0;
            init_row   <= 3'd0;
            last_gnt   <= 1'b1;
            front      <= INIT_FRAME;
            back       <= INIT_FRAME;
            swap_pulse <= 1'b0;
        end else begin
            // scan_idx mirrors the driver's row counter; both share this reset
            scan_idx   <= scan_idx + 3'd1;
            swap_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt0) begin
                        back[row_sel(row0) +: LED_COLS] <= data0;
                        last_gnt <= 1'b0;
                        if (commit0) state <= ST_PEND_SWAP;
                    end else if (gnt1) begin
                        back[row_sel(row1) +: LED_COLS] <= data1;
                        last_gnt <= 1'b1;
                        if (commit1) state <= ST_PEND_SWAP;
                    end
                end
                ST_PEND_SWAP: begin
                    if (scan_idx == 3'd7) begin
                        front      <= back;
                        init_row   <= 3'd0;
                        swap_pulse <= 1'b1;
                        state      <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    // front already holds the new frame, so copy mode seeds incremental drawing
                    back[row_sel(init_row) +: LED_COLS] <=
                        SWAP_MODE ? 8'h00 : front[row_sel(init_row) +: LED_COLS];
                    init_row <= init_row + 3'd1;
                    if (init_row == 3'd7) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
